// File: rtl/aes128_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_iter_core
//  Brief    : Iterative AES-128 encryption engine, one round per clock, with
//             a ready/done handshake and a registered ciphertext output.
//  Revision : 1.0  initial release
// ============================================================================
module aes128_iter_core #(
  parameter int DONE_STICKY = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [127:0] data_out
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  // GF(2^8) multiply-by-x, reduced by 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain; 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Forward S-box: inverse followed by the affine map (rotations 1..4, +0x63).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [3:0]   rnd_q;
  logic         ready_q;
  logic         done_q;
  logic [127:0] data_out_q;

  logic [31:0]  rot_d;
  logic [31:0]  tmp_d;
  logic [127:0] nk_d;
  logic [127:0] sr_d;
  logic [127:0] round_d;

  // Next round key and next state for the round selected by rnd_q.
  always_comb begin
    rot_d   = {rk_q[23:0], rk_q[31:24]};
    tmp_d   = {sbox(rot_d[31:24]) ^ rcon(rnd_q), sbox(rot_d[23:16]),
               sbox(rot_d[15:8]), sbox(rot_d[7:0])};
    nk_d[127:96] = rk_q[127:96] ^ tmp_d;
    nk_d[95:64]  = rk_q[95:64]  ^ nk_d[127:96];
    nk_d[63:32]  = rk_q[63:32]  ^ nk_d[95:64];
    nk_d[31:0]   = rk_q[31:0]   ^ nk_d[63:32];
    sr_d    = sub_shift(state_q);
    round_d = ((rnd_q == 4'd10) ? sr_d : mix_columns(sr_d)) ^ nk_d;
  end

  // Control FSM and datapath registers; the last round publishes the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      rk_q       <= '0;
      rnd_q      <= 4'd0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (DONE_STICKY == 0) done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= data_in ^ key;
            rk_q    <= key;
            rnd_q   <= 4'd1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= round_d;
          rk_q    <= nk_d;
          if (rnd_q == 4'd10) begin
            rnd_q      <= 4'd0;
            data_out_q <= round_d;
            done_q     <= 1'b1;
            ready_q    <= 1'b1;
            fsm_q      <= IDLE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes128_iter_core
//  Brief    : Self-checking bench for aes128_iter_core (pulse and sticky done).
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes128_iter_core;

  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, start_s;
  logic [127:0] data_in, key, data_s, key_s;
  logic         ready, done, ready_s, done_s;
  logic [127:0] data_out, data_out_s;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_v;

  always #5 clk = ~clk;

  aes128_iter_core #(.DONE_STICKY(0)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .key(key),
    .ready(ready), .done(done), .data_out(data_out)
  );

  aes128_iter_core #(.DONE_STICKY(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .data_in(data_s), .key(key_s),
    .ready(ready_s), .done(done_s), .data_out(data_out_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycles until done rises on the pulse instance; -1 when the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_done_s(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done_s === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    data_in = '0; key = '0; data_s = '0; key_s = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
    checks++; if (done_s !== 1'b0 || ready_s !== 1'b1) begin errors++; $display("FAIL reset_sticky: got done=%b ready=%b expected done=0 ready=1", done_s, ready_s); end
  endtask

  task automatic test_vector(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
    int lat;
    start = 1'b1; data_in = p; key = k;
    exp_q.push_back(c);
    tick();
    start = 1'b0; data_in = ~p; key = ~k;
    wait_done(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL vec_latency: got %0d expected 10", lat); end
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL vec_data: got %h expected %h", data_out, exp_v); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL vec_ready: got %b expected 1", ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL vec_pulse: got %b expected 0", done); end
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL vec_hold: got %h expected %h", data_out, exp_v); end
  endtask

  task automatic test_midrun;
    int lat;
    int extra;
    start = 1'b1; data_in = P1; key = K1;
    exp_q.push_back(C1);
    tick();
    start = 1'b0;
    tick(); tick();
    data_in = P2; key = K2;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL mid_latency: got %0d expected 5", lat); end
    exp_v = exp_q.pop_front();
    checks++; if (data_out !== exp_v) begin errors++; $display("FAIL mid_data: got %h expected %h", data_out, exp_v); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL mid_not_queued: got %0d dones expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    start = 1'b1; data_in = P2; key = K2;
    for (int i = 0; i < 3; i++) exp_q.push_back(C2);
    tick();
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_done = (k == 10) || (k == 21) || (k == 32);
      checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done_c%0d: got %b expected %b", k, done, exp_done); end
      if (done === 1'b1 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (data_out !== exp_v) begin errors++; $display("FAIL b2b_data_c%0d: got %h expected %h", k, data_out, exp_v); end
      end
      if (k == 32) start = 1'b0;
    end
    tick();
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_end: got done=%b ready=%b expected done=0 ready=1", done, ready); end
    exp_q.delete();
  endtask

  task automatic test_reset_midrun;
    int extra;
    start = 1'b1; data_in = P1; key = K1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
    checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", data_out); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rst_mid_abort: got %0d dones expected 0", extra); end
    test_vector(P1, K1, C1);
  endtask

  task automatic test_sticky;
    int lat;
    int high;
    start_s = 1'b1; data_s = P1; key_s = K1;
    exp_q.push_back(C1);
    tick();
    start_s = 1'b0;
    wait_done_s(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL sticky_latency: got %0d expected 10", lat); end
    exp_v = exp_q.pop_front();
    checks++; if (data_out_s !== exp_v) begin errors++; $display("FAIL sticky_data1: got %h expected %h", data_out_s, exp_v); end
    high = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_s === 1'b1) high++;
    end
    checks++; if (high != 20) begin errors++; $display("FAIL sticky_hold: got %0d high cycles expected 20", high); end
    start_s = 1'b1; data_s = P2; key_s = K2;
    exp_q.push_back(C2);
    tick();
    start_s = 1'b0;
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", done_s); end
    wait_done_s(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL sticky_latency2: got %0d expected 10", lat); end
    exp_v = exp_q.pop_front();
    checks++; if (data_out_s !== exp_v) begin errors++; $display("FAIL sticky_data2: got %h expected %h", data_out_s, exp_v); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector(P1, K1, C1);
    test_vector(P2, K2, C2);
    test_midrun();
    test_back_to_back();
    test_reset_midrun();
    test_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption engine that computes one round per clock.
- Consumes the 128-bit plaintext and 128-bit key assembled by the CPU-side Avalon register interface, and returns a 128-bit ciphertext with a ready/done handshake.
- Replaces the fixed-latency core, so software polls a real completion flag instead of a cycle count.

Parameters:
- DONE_STICKY, 0, 0: done is a one-cycle pulse; 1: done holds high until the next accepted start or reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to encrypt; sampled only while ready=1.
- data_in  input  128  plaintext; bits [127:120] are byte 0 (FIPS-197 order).
- key  input  128  cipher key, same byte order.
- ready  output  1  high when IDLE and able to accept start.
- done  output  1  completion flag; see DONE_STICKY.
- data_out  output  128  ciphertext, registered; holds until the next completion.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset values: ready=1, done=0, data_out=0, state register=0, round key=0, round counter=0, FSM=IDLE.
- Reset mid-operation aborts the encryption. No done is produced, and data_out returns to 0.
- FSM states: IDLE and RUN.
- IDLE -> RUN on an edge with start=1. On that edge:
  - state <= data_in ^ key
  - rk <= key
  - rnd <= 1
  - ready <= 0
  - if DONE_STICKY=1, done <= 0
- data_in and key are captured only on the accept edge. Later changes on those inputs do not affect the result.
- RUN: each edge performs round rnd (1..10):
  - nk = KeyExpand(rk, Rcon[rnd]), with Rcon = 01,02,04,08,10,20,40,80,1B,36.
  - Rounds 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ nk.
  - Round 10: MixColumns is omitted.
  - rk <= nk; rnd <= rnd+1.
- Edge with rnd=10:
  - data_out <= final state
  - done <= 1
  - ready <= 1
  - FSM -> IDLE
- Latency: start accepted at edge E, done and data_out valid after edge E+10, i.e. 11 clocks from start to the done cycle. Throughput is one block per 11 clocks.
- With DONE_STICKY=0, done is high exactly one cycle. If start is asserted in that same cycle, it is accepted because ready=1.
- start while ready=0 is ignored. It is not queued and does not disturb the computation.
- S-box: GF(2^8) multiplicative inverse (poly 0x11B, inverse of 0 = 0) followed by the FIPS-197 affine transform. The implementation may use an arithmetic or table form, but all 16 state S-boxes and 4 key S-boxes must be combinational within a single cycle.
- Width rules:
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0), kept to 8 bits.
  - The round counter is 4 bits and never exceeds 10 in RUN.

Test Plan:
- Reset, then start with data_in=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f -> done after 11 clocks; data_out=69c4e0d86a7b0430d8cdb78070b4c55a; ready=1 in the done cycle.
- data_in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> data_out=3925841d02dc09fbdc118597196a0b32.
- Drive these mid-run on the first vector's run:
  - pulse start with vector 2 at round 5 -> ignored; first result unchanged.
  - change data_in/key at round 3 -> first result unchanged.
- Back-to-back operation: hold start=1 continuously -> completions every 11 clocks. With DONE_STICKY=0, done is high exactly 1 cycle per block; the second start is accepted in the first done cycle.
- Assert reset at round 6 -> next cycle: ready=1, done=0, data_out=0. A fresh start then yields a correct vector 1 result.
- DONE_STICKY=1 -> done stays high across 20 idle cycles and clears on the accept edge of the next start.
